regfile_wb_arbiter: RTL and testbench

- Writeback controller in front of the 32x64 integer register file, which has a single write port (wen/wAddr/wData).
- Shares that port round-robin between NUM_REQ writeback sources (ALU, LSU, CSR) using valid/ready handshakes.
- Drives the write port from registered outputs.
- Keeps a per-register busy scoreboard so decode can stall on operands that still have a write pending.

---
 rtl/regfile_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a single-write-port register file: round-robin grant
// among NUM_REQ sources, registered write port, and a per-register busy scoreboard.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 64,
    parameter int AW      = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*AW-1:0]     req_addr,
    input  logic [NUM_REQ*XLEN-1:0]   req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      wen,
    output logic [AW-1:0]             wAddr,
    output logic [XLEN-1:0]           wData,
    input  logic                      alloc_valid,
    input  logic [AW-1:0]             alloc_addr,
    input  logic [AW-1:0]             rs1Addr,
    input  logic [AW-1:0]             rs2Addr,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    input  logic                      flush,
    output logic [(1<<AW)-1:0]        busy_vec
);

    localparam int NREG = 1 << AW;
    localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]   gidx;
    logic            xfer;
    logic [AW-1:0]   addr_arr [NUM_REQ];
    logic [XLEN-1:0] data_arr [NUM_REQ];

    logic            wen_q, wen_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [NREG-1:0] busy_q, busy_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*AW +: AW];
            assign data_arr[gi] = req_data[gi*XLEN +: XLEN];
        end
    endgenerate

    // Priority search starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        int            sum;
        logic [PW-1:0] idx;
        grant = '0;
        gidx  = '0;
        xfer  = 1'b0;
        sum   = 0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(ptr_q) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = PW'(sum);
            if (!xfer && req_valid[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
                xfer       = 1'b1;
            end
        end
    end

    assign req_ready = reset ? grant : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
        end
    end

    // Writes to x0 are granted but swallowed; wAddr/wData hold on idle cycles.
    always_comb begin
        wen_d   = xfer && (addr_arr[gidx] != '0);
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (wen_d) begin
            waddr_d = addr_arr[gidx];
            wdata_d = data_arr[gidx];
        end
    end

    // Clear on retiring write, then set (newer producer wins), then flush overrides all.
    always_comb begin
        busy_d = busy_q;
        if (wen_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (alloc_valid && (alloc_addr != '0)) begin
            busy_d[alloc_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q   <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign wen      = wen_q;
    assign wAddr    = waddr_q;
    assign wData    = wdata_q;
    assign busy_vec = busy_q;
    assign rs1_busy = (rs1Addr != '0) && busy_q[rs1Addr];
    assign rs2_busy = (rs2Addr != '0) && busy_q[rs2Addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter: arbitration order, write port
// latency, scoreboard set/clear/flush and asynchronous reset.
module tb_regfile_wb_arbiter;

    logic          clock;
    logic          reset;
    logic [2:0]    req_valid;
    logic [14:0]   req_addr;
    logic [191:0]  req_data;
    logic [2:0]    req_ready;
    logic          wen;
    logic [4:0]    wAddr;
    logic [63:0]   wData;
    logic          alloc_valid;
    logic [4:0]    alloc_addr;
    logic [4:0]    rs1Addr;
    logic [4:0]    rs2Addr;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          flush;
    logic [31:0]   busy_vec;

    int vectors;
    int miscompares;

    regfile_wb_arbiter #(.NUM_REQ(3), .XLEN(64), .AW(5)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .wen(wen), .wAddr(wAddr), .wData(wData),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .flush(flush), .busy_vec(busy_vec)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [63:0] d);
        req_addr[i*5 +: 5]  = a;
        req_data[i*64 +: 64] = d;
    endtask

    task automatic test_reset();
        req_valid = 3'b111;
        #1;
        vectors++;
        if (req_ready !== 3'b000) begin miscompares++; $display("FAIL reset_ready: got %b want 000", req_ready); end
        vectors++;
        if ({wen, wAddr, wData} !== {1'b0, 5'd0, 64'd0}) begin miscompares++; $display("FAIL reset_port: got wen=%b addr=%0d data=%h want 0/0/0", wen, wAddr, wData); end
        vectors++;
        if (busy_vec !== 32'd0) begin miscompares++; $display("FAIL reset_busy: got %h want 0", busy_vec); end
        req_valid = 3'b000;
        tick();
        reset = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_round_robin();
        set_req(0, 5'd1, 64'hA);
        set_req(1, 5'd2, 64'hB);
        set_req(2, 5'd3, 64'hC);
        req_valid = 3'b111;
        #1;
        vectors++;
        if (req_ready !== 3'b001) begin miscompares++; $display("FAIL rr_grant0: got %b want 001", req_ready); end
        vectors++;
        if (wen !== 1'b0) begin miscompares++; $display("FAIL rr_wen_idle: got %b want 0", wen); end
        tick();
        vectors++;
        if (req_ready !== 3'b010) begin miscompares++; $display("FAIL rr_grant1: got %b want 010", req_ready); end
        vectors++;
        if ({wen, wAddr, wData} !== {1'b1, 5'd1, 64'hA}) begin miscompares++; $display("FAIL rr_write0: got %b/%0d/%h want 1/1/a", wen, wAddr, wData); end
        tick();
        vectors++;
        if (req_ready !== 3'b100) begin miscompares++; $display("FAIL rr_grant2: got %b want 100", req_ready); end
        vectors++;
        if ({wen, wAddr, wData} !== {1'b1, 5'd2, 64'hB}) begin miscompares++; $display("FAIL rr_write1: got %b/%0d/%h want 1/2/b", wen, wAddr, wData); end
        tick();
        req_valid = 3'b000;
        #1;
        vectors++;
        if ({wen, wAddr, wData} !== {1'b1, 5'd3, 64'hC}) begin miscompares++; $display("FAIL rr_write2: got %b/%0d/%h want 1/3/c", wen, wAddr, wData); end
        tick();
        vectors++;
        if ({wen, wAddr, wData} !== {1'b0, 5'd3, 64'hC}) begin miscompares++; $display("FAIL rr_hold: got %b/%0d/%h want 0/3/c", wen, wAddr, wData); end
        $display("test_round_robin done");
    endtask

    task automatic test_single_req();
        set_req(0, 5'd4, 64'h44);
        req_valid = 3'b001;
        #1;
        vectors++;
        if (req_ready !== 3'b001) begin miscompares++; $display("FAIL single_pre: got %b want 001", req_ready); end
        tick();
        set_req(2, 5'd7, 64'hDEAD);
        req_valid = 3'b100;
        #1;
        vectors++;
        if (req_ready !== 3'b100) begin miscompares++; $display("FAIL single_grant2: got %b want 100", req_ready); end
        tick();
        req_valid = 3'b111;
        #1;
        vectors++;
        if ({wen, wAddr, wData} !== {1'b1, 5'd7, 64'hDEAD}) begin miscompares++; $display("FAIL single_write: got %b/%0d/%h want 1/7/dead", wen, wAddr, wData); end
        vectors++;
        if (req_ready !== 3'b001) begin miscompares++; $display("FAIL single_ptr_wrap: got %b want 001", req_ready); end
        tick();
        req_valid = 3'b000;
        tick();
        $display("test_single_req done");
    endtask

    task automatic test_scoreboard();
        alloc_valid = 1'b1;
        alloc_addr  = 5'd5;
        rs1Addr     = 5'd5;
        rs2Addr     = 5'd6;
        #1;
        vectors++;
        if (rs1_busy !== 1'b0) begin miscompares++; $display("FAIL sb_no_bypass: got %b want 0", rs1_busy); end
        tick();
        alloc_valid = 1'b0;
        #1;
        vectors++;
        if (busy_vec !== 32'h20) begin miscompares++; $display("FAIL sb_set: got %h want 00000020", busy_vec); end
        vectors++;
        if ({rs1_busy, rs2_busy} !== 2'b10) begin miscompares++; $display("FAIL sb_rs: got %b want 10", {rs1_busy, rs2_busy}); end
        tick();
        tick();
        set_req(1, 5'd5, 64'h55);
        req_valid = 3'b010;
        #1;
        vectors++;
        if (req_ready !== 3'b010) begin miscompares++; $display("FAIL sb_grant: got %b want 010", req_ready); end
        tick();
        req_valid = 3'b000;
        #1;
        vectors++;
        if ({wen, wAddr, busy_vec} !== {1'b1, 5'd5, 32'h20}) begin miscompares++; $display("FAIL sb_wen_cycle: got %b/%0d/%h want 1/5/00000020", wen, wAddr, busy_vec); end
        tick();
        vectors++;
        if ({busy_vec, rs1_busy} !== {32'h0, 1'b0}) begin miscompares++; $display("FAIL sb_clear: got %h/%b want 0/0", busy_vec, rs1_busy); end
        $display("test_scoreboard done");
    endtask

    task automatic test_collision();
        alloc_valid = 1'b1;
        alloc_addr  = 5'd9;
        tick();
        alloc_valid = 1'b0;
        set_req(0, 5'd9, 64'h99);
        req_valid = 3'b001;
        #1;
        vectors++;
        if (req_ready !== 3'b001) begin miscompares++; $display("FAIL col_grant: got %b want 001", req_ready); end
        tick();
        req_valid   = 3'b000;
        alloc_valid = 1'b1;
        alloc_addr  = 5'd9;
        #1;
        vectors++;
        if ({wen, wAddr, busy_vec} !== {1'b1, 5'd9, 32'h200}) begin miscompares++; $display("FAIL col_pre: got %b/%0d/%h want 1/9/00000200", wen, wAddr, busy_vec); end
        tick();
        alloc_valid = 1'b0;
        #1;
        vectors++;
        if (busy_vec !== 32'h200) begin miscompares++; $display("FAIL col_set_wins: got %h want 00000200", busy_vec); end
        req_valid = 3'b001;
        tick();
        req_valid   = 3'b000;
        alloc_valid = 1'b1;
        alloc_addr  = 5'd10;
        tick();
        alloc_valid = 1'b0;
        #1;
        vectors++;
        if (busy_vec !== 32'h400) begin miscompares++; $display("FAIL col_diff_addr: got %h want 00000400", busy_vec); end
        set_req(2, 5'd0, 64'h123);
        req_valid = 3'b100;
        #1;
        vectors++;
        if (req_ready !== 3'b100) begin miscompares++; $display("FAIL x0_ready: got %b want 100", req_ready); end
        tick();
        req_valid = 3'b000;
        #1;
        vectors++;
        if ({wen, wAddr, busy_vec} !== {1'b0, 5'd9, 32'h400}) begin miscompares++; $display("FAIL x0_no_write: got %b/%0d/%h want 0/9/00000400", wen, wAddr, busy_vec); end
        tick();
        vectors++;
        if (busy_vec !== 32'h400) begin miscompares++; $display("FAIL x0_busy: got %h want 00000400", busy_vec); end
        $display("test_collision done");
    endtask

    task automatic test_flush();
        alloc_valid = 1'b1;
        alloc_addr  = 5'd1;
        tick();
        alloc_addr  = 5'd2;
        tick();
        alloc_addr  = 5'd31;
        set_req(1, 5'd1, 64'h1111);
        req_valid = 3'b010;
        tick();
        flush      = 1'b1;
        alloc_addr = 5'd4;
        set_req(0, 5'd6, 64'h66);
        req_valid = 3'b001;
        #1;
        vectors++;
        if (busy_vec !== 32'h8000_0406) begin miscompares++; $display("FAIL fl_pre: got %h want 80000406", busy_vec); end
        vectors++;
        if ({wen, wAddr, wData} !== {1'b1, 5'd1, 64'h1111}) begin miscompares++; $display("FAIL fl_inflight: got %b/%0d/%h want 1/1/1111", wen, wAddr, wData); end
        vectors++;
        if (req_ready !== 3'b001) begin miscompares++; $display("FAIL fl_grant: got %b want 001", req_ready); end
        tick();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        req_valid   = 3'b000;
        #1;
        vectors++;
        if (busy_vec !== 32'h0) begin miscompares++; $display("FAIL fl_clear: got %h want 0", busy_vec); end
        vectors++;
        if ({wen, wAddr, wData} !== {1'b1, 5'd6, 64'h66}) begin miscompares++; $display("FAIL fl_write: got %b/%0d/%h want 1/6/66", wen, wAddr, wData); end
        tick();
        $display("test_flush done");
    endtask

    task automatic test_async_reset();
        alloc_valid = 1'b1;
        alloc_addr  = 5'd3;
        tick();
        alloc_valid = 1'b0;
        set_req(0, 5'd3, 64'h33);
        req_valid = 3'b001;
        tick();
        req_valid = 3'b111;
        #1;
        vectors++;
        if ({wen, wAddr, busy_vec} !== {1'b1, 5'd3, 32'h8}) begin miscompares++; $display("FAIL ar_pre: got %b/%0d/%h want 1/3/00000008", wen, wAddr, busy_vec); end
        vectors++;
        if (req_ready !== 3'b010) begin miscompares++; $display("FAIL ar_ptr_pre: got %b want 010", req_ready); end
        #1;
        reset = 1'b0;
        #1;
        vectors++;
        if ({wen, wAddr, wData, busy_vec, req_ready} !== {1'b0, 5'd0, 64'd0, 32'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL ar_async: got wen=%b addr=%0d data=%h busy=%h ready=%b want all 0", wen, wAddr, wData, busy_vec, req_ready);
        end
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 3'b001) begin miscompares++; $display("FAIL ar_restart: got %b want 001", req_ready); end
        req_valid = 3'b000;
        tick();
        $display("test_async_reset done");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        req_valid   = 3'b000;
        req_addr    = '0;
        req_data    = '0;
        alloc_valid = 1'b0;
        alloc_addr  = '0;
        rs1Addr     = '0;
        rs2Addr     = '0;
        flush       = 1'b0;
        test_reset();
        test_round_robin();
        test_single_req();
        test_scoreboard();
        test_collision();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
